// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (youngest producer wins) plus load-use stall FSM for the pipelined datapath.
// Define FWD_HAZARD_PERF_EN to build the stall/forward performance counters; otherwise they read 0.
module fwd_hazard_unit #(
    parameter int NSRC   = 2,
    parameter int NFWD   = 2,
    parameter int REGW   = 5,
    parameter int LU_LAT = 1,
    localparam int SELW  = $clog2(NFWD + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NSRC*REGW-1:0]   ex_src,
    input  logic [NSRC*REGW-1:0]   id_src,
    input  logic                   ex_ld,
    input  logic                   ex_wen,
    input  logic [REGW-1:0]        ex_dst,
    input  logic [NFWD-1:0]        prod_wen,
    input  logic [NFWD*REGW-1:0]   prod_dst,
    input  logic                   freeze,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            fwd_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [3:0] HOLD_INIT = 4'(LU_LAT - 1);

    logic [0:0] state;
    logic [0:0] state_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic       src_hit;
    logic       det;
    logic       stall_d;

    // Scan producers oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (prod_wen[k] &&
                    (prod_dst[k*REGW +: REGW] != '0) &&
                    (prod_dst[k*REGW +: REGW] == ex_src[i*REGW +: REGW])) begin
                    fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src[i*REGW +: REGW] == ex_dst) begin
                src_hit = 1'b1;
            end
        end
    end

    assign det = ex_ld & ex_wen & (ex_dst != '0) & src_hit & ~flush;

    // The detect cycle itself is the first stall cycle; HOLD covers the remaining LU_LAT-1.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stall_d = 1'b0;
        case (state)
            ST_RUN: begin
                stall_d = det;
                if (det && (LU_LAT > 1) && !freeze) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    stall_d = 1'b1;
                    if (!freeze) begin
                        cnt_d = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    assign stall = stall_d;

`ifdef FWD_HAZARD_PERF_EN
    logic        any_fwd;
    logic [31:0] stall_q;
    logic [31:0] fwd_q;

    assign any_fwd = |fwd_sel;

    // Frozen cycles are not counted; both counters wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else if (!freeze) begin
            if (stall_d) begin
                stall_q <= stall_q + 32'd1;
            end
            if (any_fwd) begin
                fwd_q <= fwd_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign fwd_cnt   = fwd_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
